multiplier8bits_top: RTL and testbench



---
 rtl/multiplier8bits_top.sv | 173 +++++++++++++++++
 tb/tb_multiplier8bits_top.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/multiplier8bits_top.sv
// rtl/multiplier8bits_top.sv - 8x8 unsigned sequential multiplier built from nibble partial products
module FD_multiplier8bits (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  sel_rom,
  input  logic [1:0]  sel_soma,
  input  logic        ld_xy,
  input  logic        ld_de0,
  input  logic        ld_a,
  input  logic        ld_b,
  input  logic        ld_de1,
  input  logic        ld_ab,
  input  logic        ld_de_abshift,
  input  logic        ld_res,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] result
);
  logic [7:0]  x_r, y_r, d_r, e_r, a_r, b_r;
  logic [8:0]  ab_r;
  logic [15:0] t_r;
  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] sum;

  always_comb begin
    nib_a = x_r[3:0];
    nib_b = y_r[3:0];
    case (sel_rom)
      2'b01:   begin nib_a = x_r[3:0]; nib_b = y_r[7:4]; end
      2'b10:   begin nib_a = x_r[7:4]; nib_b = y_r[3:0]; end
      2'b11:   begin nib_a = x_r[7:4]; nib_b = y_r[7:4]; end
      default: begin nib_a = x_r[3:0]; nib_b = y_r[3:0]; end
    endcase
  end

  // Shared 4x4 product table; the result always fits in 8 bits (max 225)
  assign pp = {4'b0000, nib_a} * {4'b0000, nib_b};

  always_comb begin
    case (sel_soma)
      2'b00:   sum = {8'h00, a_r} + {8'h00, b_r};
      2'b01:   sum = {e_r, d_r} + {3'b000, ab_r, 4'b0000};
      default: sum = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= '0;
      y_r    <= '0;
      d_r    <= '0;
      e_r    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      ab_r   <= '0;
      t_r    <= '0;
      result <= '0;
    end else begin
      if (ld_xy) begin
        x_r <= x;
        y_r <= y;
      end
      if (ld_de0)        d_r    <= pp;
      if (ld_a)          a_r    <= pp;
      if (ld_b)          b_r    <= pp;
      if (ld_de1)        e_r    <= pp;
      if (ld_ab)         ab_r   <= sum[8:0];
      if (ld_de_abshift) t_r    <= sum;
      if (ld_res)        result <= t_r;
    end
  end
endmodule

module UC_multiplier8bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] sel_rom,
  output logic [1:0] sel_soma,
  output logic       ld_xy,
  output logic       ld_de0,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_de1,
  output logic       ld_ab,
  output logic       ld_de_abshift,
  output logic       ld_res,
  output logic       done
);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_P0, S_P1, S_P2, S_SUM, S_P3, S_SHIFT, S_RES, S_DONE
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_next = S_P0;
      S_P0:    state_next = S_P1;
      S_P1:    state_next = S_P2;
      S_P2:    state_next = S_SUM;
      S_SUM:   state_next = S_P3;
      S_P3:    state_next = S_SHIFT;
      S_SHIFT: state_next = S_RES;
      S_RES:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sel_rom       = 2'b00;
    sel_soma      = 2'b00;
    ld_xy         = 1'b0;
    ld_de0        = 1'b0;
    ld_a          = 1'b0;
    ld_b          = 1'b0;
    ld_de1        = 1'b0;
    ld_ab         = 1'b0;
    ld_de_abshift = 1'b0;
    ld_res        = 1'b0;
    done          = 1'b0;
    case (state)
      S_LOAD:  ld_xy = 1'b1;
      S_P0:    ld_de0 = 1'b1;
      S_P1:    begin sel_rom = 2'b01; ld_a = 1'b1; end
      S_P2:    begin sel_rom = 2'b10; ld_b = 1'b1; end
      S_SUM:   ld_ab = 1'b1;
      S_P3:    begin sel_rom = 2'b11; ld_de1 = 1'b1; end
      S_SHIFT: begin sel_soma = 2'b01; ld_de_abshift = 1'b1; end
      S_RES:   ld_res = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end
endmodule

module multiplier8bits_top (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] result,
  output logic        DONE
);
  logic [1:0] sel_rom, sel_soma;
  logic       ld_xy, ld_de0, ld_a, ld_b, ld_de1, ld_ab, ld_de_abshift, ld_res;

  UC_multiplier8bits u_uc (
    .clk(CLK), .rst_n(RESET), .start(start),
    .sel_rom(sel_rom), .sel_soma(sel_soma),
    .ld_xy(ld_xy), .ld_de0(ld_de0), .ld_a(ld_a), .ld_b(ld_b),
    .ld_de1(ld_de1), .ld_ab(ld_ab), .ld_de_abshift(ld_de_abshift),
    .ld_res(ld_res), .done(DONE)
  );

  FD_multiplier8bits u_fd (
    .clk(CLK), .rst_n(RESET),
    .sel_rom(sel_rom), .sel_soma(sel_soma),
    .ld_xy(ld_xy), .ld_de0(ld_de0), .ld_a(ld_a), .ld_b(ld_b),
    .ld_de1(ld_de1), .ld_ab(ld_ab), .ld_de_abshift(ld_de_abshift),
    .ld_res(ld_res), .x(x), .y(y), .result(result)
  );
endmodule

// File: tb/tb_multiplier8bits_top.sv
// tb/tb_multiplier8bits_top.sv - randomized self-checking bench for multiplier8bits_top
module tb_multiplier8bits_top;
  logic        CLK, RESET, start;
  logic [7:0]  x, y;
  logic [15:0] result;
  logic        DONE;

  int total = 0;
  int bad = 0;
  int rand_dones = 0;

  multiplier8bits_top dut (
    .CLK(CLK), .RESET(RESET), .start(start),
    .x(x), .y(y), .result(result), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_pos is the position within a run (0 = waiting, 1..9 = cycles of the run)
  int          m_pos;
  logic [15:0] m_prod, m_res;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_pos  = 0;
      m_prod = 16'd0;
      m_res  = 16'd0;
    end else if (m_pos == 0) begin
      m_pos = start ? 1 : 0;
    end else begin
      if (m_pos == 1) m_prod = 16'(x) * 16'(y);
      if (m_pos == 8) m_res = m_prod;
      m_pos = (m_pos == 9) ? 0 : m_pos + 1;
    end
  end

  always @(negedge CLK) begin
    check("cyc_done", {31'd0, DONE}, {31'd0, (m_pos == 9)});
    check("cyc_result", {16'd0, result}, {16'd0, m_res});
  end

  task automatic wait_done(output int n);
    bit ok;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      n++;
      if (DONE) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int n;
    RESET = 1'b0;
    start = 1'b0;
    x = 8'd0;
    y = 8'd0;
    repeat (3) @(negedge CLK);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_done", {31'd0, DONE}, 32'd0);
    RESET = 1'b1;

    repeat (20) @(negedge CLK);
    check("idle_result", {16'd0, result}, 32'd0);
    check("idle_done", {31'd0, DONE}, 32'd0);

    x = 8'd17; y = 8'd23; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(n);
    check("lat_17x23", n, 32'd8);
    check("res_17x23", {16'd0, result}, 32'd391);
    @(negedge CLK);

    x = 8'd255; y = 8'd255; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(n);
    check("res_255x255", {16'd0, result}, 32'd65025);
    @(negedge CLK);

    x = 8'd0; y = 8'd200; start = 1'b1;
    wait_done(n);
    check("lat_0x200", n, 32'd9);
    check("res_0x200", {16'd0, result}, 32'd0);
    x = 8'd16; y = 8'd16;
    wait_done(n);
    check("spacing_held", n, 32'd10);
    check("res_16x16", {16'd0, result}, 32'd256);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    x = 8'd17; y = 8'd23; start = 1'b1;
    repeat (3) @(negedge CLK);
    x = 8'd3;
    wait_done(n);
    check("res_capture", {16'd0, result}, 32'd391);
    wait_done(n);
    check("res_3x23", {16'd0, result}, 32'd69);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    x = 8'd200; y = 8'd100; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_done", {31'd0, DONE}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (12) @(negedge CLK);
    check("post_abort_idle", {16'd0, result}, 32'd0);
    x = 8'd12; y = 8'd13; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(n);
    check("lat_restart", n, 32'd8);
    check("res_12x13", {16'd0, result}, 32'd156);
    @(negedge CLK);

    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      if (DONE) rand_dones++;
      x = 8'($urandom);
      y = 8'($urandom);
      start = ($urandom_range(0, 3) != 0);
    end
    check("rand_runs_seen", {31'd0, (rand_dones > 20)}, 32'd1);

    start = 1'b0;
    repeat (12) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
